// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: sequences one data-cache access per instruction, stalls the
// pipeline until the hit, and resolves branch/jump redirects. Optional macro: STALL_CNT_EN.
module mem_stage_ctrl #(
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic              halt,
    input  logic              Branch,
    input  logic              bne,
    input  logic              zero,
    input  logic              Jump,
    input  logic [WORD_W-1:0] addr,
    input  logic [WORD_W-1:0] store_data,
    input  logic [WORD_W-1:0] baddr,
    input  logic [WORD_W-1:0] jaddr,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic [WORD_W-1:0] load_data,
    output logic              mem_stall,
    output logic              flush,
    output logic              npc_sel,
    output logic [WORD_W-1:0] npc,
    output logic              halt_out
`ifdef STALL_CNT_EN
    ,
    output logic [31:0]       stall_cycles
`endif
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE, HALTED} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_is_wr;
    logic [WORD_W-1:0] r_addr;
    logic [WORD_W-1:0] r_wdata;
    logic [WORD_W-1:0] r_load;
    logic              w_req;
    logic              w_capture;
    logic              w_load_done;
    logic              w_in_access;
    logic              w_taken;

    assign w_req = dREN | dWEN;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_capture   = 1'b0;
        w_load_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (halt) begin
                    w_next = HALTED;
                end else if (w_req) begin
                    w_next    = ACCESS;
                    w_capture = 1'b1;
                end
            end
            ACCESS: begin
                if (dhit) begin
                    w_next      = DONE;
                    w_load_done = ~r_is_wr;
                end
            end
            DONE:    w_next = IDLE;
            HALTED:  w_next = HALTED;
            default: w_next = IDLE;
        endcase
    end

    // The request is held in local registers so it stays stable while dhit is low.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_is_wr <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_load  <= '0;
        end else begin
            if (w_capture) begin
                r_is_wr <= dWEN;
                r_addr  <= addr;
                r_wdata <= store_data;
            end
            if (w_load_done) begin
                r_load <= dmemload;
            end
        end
    end

    assign w_in_access = (r_state == ACCESS);
    assign dmemREN     = w_in_access & ~r_is_wr;
    assign dmemWEN     = w_in_access & r_is_wr;
    assign dmemaddr    = w_in_access ? r_addr  : '0;
    assign dmemstore   = w_in_access ? r_wdata : '0;
    assign load_data   = r_load;
    assign halt_out    = (r_state == HALTED);
    assign mem_stall   = w_in_access | ((r_state == IDLE) & w_req & ~halt);

    // Redirects wait until the memory stage is free so a stalled instruction is not lost.
    assign w_taken = Branch & (zero ^ bne);
    assign flush   = (w_taken | Jump) & ~mem_stall & ~halt_out;
    assign npc_sel = flush;
    assign npc     = Jump ? jaddr : baddr;

`ifdef STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_stall_cnt <= '0;
        end else if (mem_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cnt;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed and randomized memory/branch/halt scenarios
// checked against a transaction-level expectation model.
module tb_mem_stage_ctrl;
  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         nRST;
  logic         dREN, dWEN, halt, Branch, bne, zero, Jump, dhit;
  logic [W-1:0] addr, store_data, baddr, jaddr, dmemload;
  logic         dmemREN, dmemWEN, mem_stall, flush, npc_sel, halt_out;
  logic [W-1:0] dmemaddr, dmemstore, load_data, npc;
`ifdef STALL_CNT_EN
  logic [31:0]  stall_cycles;
`endif

  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] exp_load;
  logic [31:0]  exp_stall;

  mem_stage_ctrl #(.WORD_W(W)) dut (
    .CLK(CLK), .nRST(nRST),
    .dREN(dREN), .dWEN(dWEN), .halt(halt), .Branch(Branch), .bne(bne), .zero(zero), .Jump(Jump),
    .addr(addr), .store_data(store_data), .baddr(baddr), .jaddr(jaddr),
    .dhit(dhit), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .load_data(load_data), .mem_stall(mem_stall), .flush(flush), .npc_sel(npc_sel), .npc(npc),
    .halt_out(halt_out)
`ifdef STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    dREN = 0; dWEN = 0; halt = 0; Branch = 0; bne = 0; zero = 0; Jump = 0; dhit = 0;
    addr = '0; store_data = '0; baddr = '0; jaddr = '0; dmemload = '0;
  endtask

  // One memory instruction from IDLE through DONE and back to IDLE.
  // ctl = {Branch, bne, zero, Jump}; hd = number of miss cycles before dhit.
  task automatic do_mem(input logic rd, input logic wr, input logic [W-1:0] a, input logic [W-1:0] d,
                        input int hd, input logic [W-1:0] ld, input logic [3:0] ctl, input logic rnd_halt);
    logic ren_e, wen_e, exp_flush;
    int   nstall, nren, nwen;
    ren_e = rd & ~wr;
    wen_e = wr;
    nstall = 0; nren = 0; nwen = 0;
    dREN = rd; dWEN = wr; addr = a; store_data = d; halt = 0; dhit = 0;
    {Branch, bne, zero, Jump} = ctl;
    baddr = $urandom; jaddr = $urandom;
    exp_flush = (ctl[3] & (ctl[1] ^ ctl[2])) | ctl[0];
    #1;
    checks++;
    if ({mem_stall, dmemREN, dmemWEN, flush} !== 4'b1000) begin
      errors++;
      $display("FAIL idle_req: got stall/ren/wen/flush=%b want 1000", {mem_stall, dmemREN, dmemWEN, flush});
    end
    nstall += int'(mem_stall);
    for (int k = 0; k <= hd; k++) begin
      step();
      dhit = (k == hd);
      dmemload = (k == hd) ? ld : W'($urandom);
      halt = rnd_halt ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      checks++;
      if ({dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall, flush, halt_out} !==
          {ren_e, wen_e, a, d, 1'b1, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL access_req: got ren=%b wen=%b addr=%h st=%h stall=%b flush=%b ho=%b want ren=%b wen=%b addr=%h st=%h stall=1 flush=0 ho=0",
                 dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall, flush, halt_out, ren_e, wen_e, a, d);
      end
      nstall += int'(mem_stall);
      nren   += int'(dmemREN);
      nwen   += int'(dmemWEN);
    end
    step();
    dhit = 0; halt = 0; dmemload = W'($urandom);
    #1;
    if (ren_e) exp_load = ld;
    checks++;
    if ({mem_stall, dmemREN, dmemWEN, halt_out, flush} !== {4'b0000, exp_flush}) begin
      errors++;
      $display("FAIL done_ctrl: got stall/ren/wen/ho/flush=%b want %b",
               {mem_stall, dmemREN, dmemWEN, halt_out, flush}, {4'b0000, exp_flush});
    end
    checks++;
    if (load_data !== exp_load) begin
      errors++;
      $display("FAIL load_data: got %h want %h", load_data, exp_load);
    end
    checks++;
    if (nstall !== hd + 2) begin
      errors++;
      $display("FAIL stall_len: got %0d want %0d", nstall, hd + 2);
    end
    checks++;
    if (nren !== (ren_e ? hd + 1 : 0) || nwen !== (wen_e ? hd + 1 : 0)) begin
      errors++;
      $display("FAIL req_len: got ren=%0d wen=%0d want ren=%0d wen=%0d",
               nren, nwen, ren_e ? hd + 1 : 0, wen_e ? hd + 1 : 0);
    end
    exp_stall += 32'(hd + 2);
    step();
    clear_inputs();
    #1;
    checks++;
    if ({dmemREN, dmemWEN, mem_stall} !== 3'b000) begin
      errors++;
      $display("FAIL no_reissue: got ren/wen/stall=%b want 000", {dmemREN, dmemWEN, mem_stall});
    end
`ifdef STALL_CNT_EN
    checks++;
    if (stall_cycles !== exp_stall) begin
      errors++;
      $display("FAIL stall_cnt: got %0d want %0d", stall_cycles, exp_stall);
    end
`endif
  endtask

  task automatic test_reset();
    clear_inputs();
    nRST = 0;
    exp_load = '0;
    exp_stall = '0;
    step();
    step();
    checks++;
    if ({dmemREN, dmemWEN, dmemaddr, dmemstore, load_data, mem_stall, flush, npc_sel, halt_out} !== '0) begin
      errors++;
      $display("FAIL reset_outs: got ren=%b wen=%b addr=%h st=%h ld=%h stall=%b flush=%b ho=%b want all 0",
               dmemREN, dmemWEN, dmemaddr, dmemstore, load_data, mem_stall, flush, halt_out);
    end
`ifdef STALL_CNT_EN
    checks++;
    if (stall_cycles !== 32'd0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d want 0", stall_cycles);
    end
`endif
    nRST = 1;
    step();
  endtask

  task automatic test_load();
    do_mem(1'b1, 1'b0, 32'h100, 32'h0, 2, 32'hDEADBEEF, 4'b0000, 1'b0);
  endtask

  task automatic test_store();
    do_mem(1'b0, 1'b1, 32'h200, 32'h12345678, 0, 32'hCAFEF00D, 4'b0000, 1'b0);
  endtask

  task automatic test_branch();
    logic [3:0]   ctl;
    logic [W-1:0] ba, ja;
    logic         exp_f;
    for (int i = 0; i < 26; i++) begin
      if (i == 0) begin
        ctl = 4'b1100; ba = 32'h40; ja = $urandom;
      end else if (i == 1) begin
        ctl = 4'b1011; ba = 32'h40; ja = 32'h80;
      end else begin
        ctl = 4'($urandom); ba = $urandom; ja = $urandom;
      end
      {Branch, bne, zero, Jump} = ctl;
      baddr = ba; jaddr = ja; dREN = 0; dWEN = 0; halt = 0;
      exp_f = (ctl[3] && (ctl[2] != ctl[1])) || ctl[0];
      #1;
      checks++;
      if ({flush, npc_sel, npc} !== {exp_f, exp_f, (ctl[0] ? ja : ba)}) begin
        errors++;
        $display("FAIL branch[%0d]: got flush=%b sel=%b npc=%h want flush=%b npc=%h",
                 i, flush, npc_sel, npc, exp_f, ctl[0] ? ja : ba);
      end
      step();
    end
    clear_inputs();
  endtask

  task automatic test_branch_pending_load();
    do_mem(1'b1, 1'b0, 32'h300, 32'h0, 1, 32'h0BADC0DE, 4'b1100, 1'b0);
    do_mem(1'b1, 1'b0, 32'h304, 32'h0, 0, 32'h13572468, 4'b1011, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [1:0] v;
    for (int i = 0; i < 14; i++) begin
      v = 2'($urandom_range(1, 3));
      do_mem(v[0], v[1], $urandom, $urandom, $urandom_range(0, 3), $urandom, 4'($urandom), 1'b1);
    end
  endtask

  task automatic test_halt();
    clear_inputs();
    halt = 1;
    step();
    halt = 0;
    for (int i = 0; i < 10; i++) begin
      dREN = 1; addr = $urandom; Jump = 1'($urandom_range(0, 1)); Branch = 1;
      #1;
      checks++;
      if ({halt_out, mem_stall, dmemREN, dmemWEN, flush} !== 5'b10000) begin
        errors++;
        $display("FAIL halted[%0d]: got ho/stall/ren/wen/flush=%b want 10000",
                 i, {halt_out, mem_stall, dmemREN, dmemWEN, flush});
      end
      step();
    end
    clear_inputs();
    nRST = 0;
    #1;
    checks++;
    if (halt_out !== 1'b0) begin
      errors++;
      $display("FAIL halt_clear: got %b want 0", halt_out);
    end
    exp_load = '0;
    exp_stall = '0;
    step();
    nRST = 1;
    step();
    do_mem(1'b1, 1'b0, 32'h400, 32'h0, 0, 32'h55AA55AA, 4'b0000, 1'b0);
  endtask

  task automatic test_reset_mid_access();
    clear_inputs();
    dREN = 1; addr = 32'h500;
    step();
    #1;
    checks++;
    if (dmemREN !== 1'b1) begin
      errors++;
      $display("FAIL mid_start: got ren=%b want 1", dmemREN);
    end
    nRST = 0;
    dREN = 0;
    #1;
    checks++;
    if ({dmemREN, dmemWEN, dmemaddr, mem_stall, load_data, halt_out} !== '0) begin
      errors++;
      $display("FAIL mid_reset: got ren=%b wen=%b addr=%h stall=%b ld=%h ho=%b want all 0",
               dmemREN, dmemWEN, dmemaddr, mem_stall, load_data, halt_out);
    end
`ifdef STALL_CNT_EN
    checks++;
    if (stall_cycles !== 32'd0) begin
      errors++;
      $display("FAIL mid_cnt: got %0d want 0", stall_cycles);
    end
`endif
    exp_load = '0;
    exp_stall = '0;
    step();
    nRST = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({dmemREN, dmemWEN, mem_stall} !== 3'b000) begin
        errors++;
        $display("FAIL no_retry[%0d]: got ren/wen/stall=%b want 000", i, {dmemREN, dmemWEN, mem_stall});
      end
    end
    do_mem(1'b0, 1'b1, 32'h600, 32'hA5A5A5A5, 1, 32'h0, 4'b0000, 1'b0);
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_branch();
    test_branch_pending_load();
    test_back_to_back();
    test_halt();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
